// File: rtl/menu_pkg.sv
// Shared definitions for the VGA menu: key codes, FSM state type,
// default colours and the hold-timer width.
package menu_pkg;

  localparam logic [1:0] KEY_NONE  = 2'b00;
  localparam logic [1:0] KEY_LEFT  = 2'b01;
  localparam logic [1:0] KEY_RIGHT = 2'b10;
  localparam logic [1:0] KEY_ENTER = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_PRESSED = 2'd2
  } menu_state_e;

  localparam logic [11:0] DEF_BG_COLOR  = 12'h0C6;
  localparam logic [11:0] DEF_BTN_COLOR = 12'h8C6;
  localparam logic [11:0] DEF_SEL_COLOR = 12'hC33;
  localparam logic [11:0] DEF_PRS_COLOR = 12'hF66;
  localparam logic [11:0] BLACK_COLOR   = 12'h000;
  localparam logic [11:0] GRID_LINE_COLOR = 12'h666;
  localparam logic [11:0] GRID_FILL_COLOR = 12'hCCC;

  // Hold timer width; covers HOLD_CYC up to 2^24-1.
  localparam int TIMER_W = 24;

endpackage

// File: rtl/menu_sel_fsm.sv
// Menu selection FSM: tracks the selected button, emits a one-cycle press
// strobe on enter and holds the PRESSED state for HOLD_CYC cycles.
module menu_sel_fsm
  import menu_pkg::*;
#(
  parameter int N_BTN    = 3,
  parameter int HOLD_CYC = 8_200_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [1:0]               key_code,
  output menu_state_e              state,
  output logic [$clog2(N_BTN)-1:0] sel_idx,
  output logic [N_BTN-1:0]         btn_pulse,
  output logic                     busy
);

  localparam int SEL_W = $clog2(N_BTN);
  localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(N_BTN - 1);
  localparam logic [TIMER_W-1:0] TIMER_TOP = TIMER_W'(HOLD_CYC - 1);

  menu_state_e        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [N_BTN-1:0]   pulse_q, pulse_d;

  // State, selection, hold timer and press strobe registers.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      timer_q <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic: key decoding, selection wrap and hold countdown.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    pulse_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid && key_code != KEY_NONE) begin
          state_d = ST_SELECT;
          sel_d   = '0;
        end
      end
      ST_SELECT: begin
        if (key_valid) begin
          case (key_code)
            KEY_RIGHT: sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            KEY_LEFT:  sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
            KEY_ENTER: begin
              state_d = ST_PRESSED;
              timer_d = TIMER_TOP;
              pulse_d = N_BTN'(1) << sel_q;
            end
            default: ;
          endcase
        end
      end
      ST_PRESSED: begin
        // Keys are dropped while the press is being shown.
        if (timer_q == '0) state_d = ST_SELECT;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state     = state_q;
  assign sel_idx   = sel_q;
  assign btn_pulse = pulse_q;
  assign busy      = (state_q == ST_PRESSED);

endmodule

// File: rtl/vga_menu_compositor.sv
// VGA menu compositor: per-pixel colour priority mux over blanking, text,
// buttons and an optional grid layer, with a registered 12-bit output.
// Build option: define VGA_MENU_GRID_EN to draw the grid layer; when it is
// undefined the grid inputs are ignored and the grid area shows background.
module vga_menu_compositor
  import menu_pkg::*;
#(
  parameter int          N_BTN     = 3,
  parameter int          HOLD_CYC  = 8_200_000,
  parameter logic [11:0] BG_COLOR  = DEF_BG_COLOR,
  parameter logic [11:0] BTN_COLOR = DEF_BTN_COLOR,
  parameter logic [11:0] SEL_COLOR = DEF_SEL_COLOR,
  parameter logic [11:0] PRS_COLOR = DEF_PRS_COLOR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [10:0]              hc_visible,
  input  logic [10:0]              vc_visible,
  input  logic [N_BTN-1:0]         in_btn,
  input  logic                     in_char,
  input  logic                     in_grid,
  input  logic                     grid_line,
  input  logic                     grid_en,
  input  logic                     key_valid,
  input  logic [1:0]               key_code,
  output logic [11:0]              vga_rgb,
  output logic [$clog2(N_BTN)-1:0] sel_idx,
  output logic [N_BTN-1:0]         btn_pulse,
  output logic                     busy
);

  localparam int SEL_W = $clog2(N_BTN);

  menu_state_e state;
  logic        sel_hit;
  logic [11:0] rgb_d;

  menu_sel_fsm #(
    .N_BTN    (N_BTN),
    .HOLD_CYC (HOLD_CYC)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .state     (state),
    .sel_idx   (sel_idx),
    .btn_pulse (btn_pulse),
    .busy      (busy)
  );

`ifndef VGA_MENU_GRID_EN
  logic grid_unused;
  assign grid_unused = ^{in_grid, grid_line, grid_en};
`endif

  // Whether the current pixel lies inside the selected button.
  always_comb begin
    sel_hit = 1'b0;
    for (int k = 0; k < N_BTN; k++) begin
      if (sel_idx == SEL_W'(k)) sel_hit = in_btn[k];
    end
  end

  // Colour priority mux; the selection only shows outside IDLE.
  always_comb begin
    rgb_d = BG_COLOR;
    if (hc_visible == '0 || vc_visible == '0)         rgb_d = BLACK_COLOR;
    else if (in_char)                                  rgb_d = BLACK_COLOR;
    else if (sel_hit && state == ST_PRESSED)           rgb_d = PRS_COLOR;
    else if (sel_hit && state == ST_SELECT)            rgb_d = SEL_COLOR;
    else if (|in_btn)                                  rgb_d = BTN_COLOR;
`ifdef VGA_MENU_GRID_EN
    else if (in_grid && grid_line && grid_en)          rgb_d = GRID_LINE_COLOR;
    else if (in_grid)                                  rgb_d = GRID_FILL_COLOR;
`endif
  end

  // Output pixel register: one clock of latency from the pixel inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vga_rgb <= '0;
    else      vga_rgb <= rgb_d;
  end

endmodule

// File: tb/tb_vga_menu_compositor.sv
// Self-checking bench for vga_menu_compositor (N_BTN=3, HOLD_CYC=4).
// Expected outputs are pushed to a scoreboard when a cycle is driven and
// compared after the following clock edge.
module tb_vga_menu_compositor;

  localparam logic [1:0] K_NONE  = 2'b00;
  localparam logic [1:0] K_LEFT  = 2'b01;
  localparam logic [1:0] K_RIGHT = 2'b10;
  localparam logic [1:0] K_ENTER = 2'b11;

  localparam int M_IDLE    = 0;
  localparam int M_SELECT  = 1;
  localparam int M_PRESSED = 2;

  logic        clk;
  logic        rst;
  logic [10:0] hc_visible;
  logic [10:0] vc_visible;
  logic [2:0]  in_btn;
  logic        in_char;
  logic        in_grid;
  logic        grid_line;
  logic        grid_en;
  logic        key_valid;
  logic [1:0]  key_code;
  logic [11:0] vga_rgb;
  logic [1:0]  sel_idx;
  logic [2:0]  btn_pulse;
  logic        busy;

  typedef struct {
    string       tag;
    logic [11:0] rgb;
    logic [1:0]  sel;
    logic        busy;
    logic [2:0]  pulse;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int busy_cnt;

  // Reference model state
  int m_state;
  int m_sel;
  int m_timer;

  vga_menu_compositor #(
    .N_BTN    (3),
    .HOLD_CYC (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hc_visible (hc_visible),
    .vc_visible (vc_visible),
    .in_btn     (in_btn),
    .in_char    (in_char),
    .in_grid    (in_grid),
    .grid_line  (grid_line),
    .grid_en    (grid_en),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .vga_rgb    (vga_rgb),
    .sel_idx    (sel_idx),
    .btn_pulse  (btn_pulse),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input logic [10:0] hc, input logic [10:0] vc,
                                            input logic [2:0] btn, input logic ch,
                                            input logic g, input logic gl, input logic ge);
    logic [11:0] c;
    c = 12'h0C6;
`ifdef VGA_MENU_GRID_EN
    if (g && gl && ge) c = 12'h666;
    else if (g)        c = 12'hCCC;
`else
    if (g || gl || ge) c = 12'h0C6;
`endif
    if (btn != 3'b000) c = 12'h8C6;
    if (m_state == M_SELECT  && btn[m_sel]) c = 12'hC33;
    if (m_state == M_PRESSED && btn[m_sel]) c = 12'hF66;
    if (ch) c = 12'h000;
    if (hc == 11'd0 || vc == 11'd0) c = 12'h000;
    return c;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_sel   = 0;
    m_timer = 0;
    sb.delete();
  endtask

  // Drive one pixel/key cycle, predict the outputs and compare after the edge.
  task automatic cycle(input string tag, input logic kv = 1'b0, input logic [1:0] kc = K_NONE,
                       input logic [2:0] btn = 3'b000, input logic ch = 1'b0,
                       input logic g = 1'b0, input logic gl = 1'b0, input logic ge = 1'b0,
                       input logic [10:0] hc = 11'd300, input logic [10:0] vc = 11'd400);
    exp_t e;
    exp_t got;
    logic [2:0] pulse;
    @(negedge clk);
    hc_visible = hc; vc_visible = vc; in_btn = btn; in_char = ch;
    in_grid = g; grid_line = gl; grid_en = ge;
    key_valid = kv; key_code = kc;
    e.tag = tag;
    e.rgb = model_rgb(hc, vc, btn, ch, g, gl, ge);
    pulse = 3'b000;
    case (m_state)
      M_IDLE: if (kv && kc != K_NONE) begin m_state = M_SELECT; m_sel = 0; end
      M_SELECT: if (kv) begin
        if (kc == K_RIGHT) m_sel = (m_sel + 1) % 3;
        else if (kc == K_LEFT) m_sel = (m_sel + 2) % 3;
        else if (kc == K_ENTER) begin
          m_state = M_PRESSED; m_timer = 3; pulse = 3'(1 << m_sel);
        end
      end
      default: if (m_timer == 0) m_state = M_SELECT; else m_timer--;
    endcase
    e.sel   = 2'(m_sel);
    e.busy  = (m_state == M_PRESSED);
    e.pulse = pulse;
    sb.push_back(e);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check({got.tag, "_rgb"},   32'(vga_rgb),   32'(got.rgb));
      check({got.tag, "_sel"},   32'(sel_idx),   32'(got.sel));
      check({got.tag, "_busy"},  32'(busy),      32'(got.busy));
      check({got.tag, "_pulse"}, 32'(btn_pulse), 32'(got.pulse));
    end
  endtask

  initial begin
    rst = 1'b0;
    hc_visible = 11'd300; vc_visible = 11'd400; in_btn = 3'b000; in_char = 1'b0;
    in_grid = 1'b0; grid_line = 1'b0; grid_en = 1'b0; key_valid = 1'b0; key_code = K_NONE;
    model_reset();

    // Reset values
    #12;
    check("rst_rgb",   32'(vga_rgb),   32'h000);
    check("rst_sel",   32'(sel_idx),   32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_pulse", 32'(btn_pulse), 32'd0);
    #1 rst = 1'b1;

    // Background pixel, then IDLE button shows the plain button colour
    cycle("bg_idle");
    check("bg_const", 32'(vga_rgb), 32'h0C6);
    cycle("idle_btn", 1'b0, K_NONE, 3'b001);
    check("idle_btn_const", 32'(vga_rgb), 32'h8C6);
    cycle("idle_nokey_right", 1'b0, K_RIGHT);
    cycle("idle_code00", 1'b1, K_NONE);

    // Enter SELECT, then walk the selection
    cycle("to_select", 1'b1, K_RIGHT);
    check("to_select_sel", 32'(sel_idx), 32'd0);
    cycle("sel_code00", 1'b1, K_NONE);
    cycle("r1", 1'b1, K_RIGHT);
    check("r1_const", 32'(sel_idx), 32'd1);
    cycle("r2", 1'b1, K_RIGHT);
    check("r2_const", 32'(sel_idx), 32'd2);
    cycle("r3", 1'b1, K_RIGHT);
    check("r3_const", 32'(sel_idx), 32'd0);
    cycle("l1", 1'b1, K_LEFT);
    check("l1_const", 32'(sel_idx), 32'd2);
    cycle("r_wrap", 1'b1, K_RIGHT);
    cycle("r_to1", 1'b1, K_RIGHT);

    // Pixel priority with sel_idx = 1 in SELECT
    cycle("px_sel", 1'b0, K_NONE, 3'b010);
    check("px_sel_const", 32'(vga_rgb), 32'hC33);
    cycle("px_other", 1'b0, K_NONE, 3'b001);
    cycle("px_overlap", 1'b0, K_NONE, 3'b011);
    cycle("px_overlap_unsel", 1'b0, K_NONE, 3'b101);
    cycle("px_char", 1'b0, K_NONE, 3'b010, 1'b1);
    check("px_char_const", 32'(vga_rgb), 32'h000);
    cycle("px_hblank", 1'b0, K_NONE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd400);
    cycle("px_vblank", 1'b0, K_NONE, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 11'd5, 11'd0);
    cycle("px_grid_line", 1'b0, K_NONE, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef VGA_MENU_GRID_EN
    check("grid_line_const", 32'(vga_rgb), 32'h666);
`else
    check("grid_line_const", 32'(vga_rgb), 32'h0C6);
`endif
    cycle("px_grid_fill", 1'b0, K_NONE, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("px_grid_btn", 1'b0, K_NONE, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1);

    // Press button 1, right key during the hold is dropped
    busy_cnt = 0;
    cycle("enter", 1'b1, K_ENTER, 3'b010);
    check("enter_pulse_const", 32'(btn_pulse), 32'h2);
    if (busy) busy_cnt++;
    cycle("prs_right", 1'b1, K_RIGHT, 3'b010);
    check("prs_rgb_const", 32'(vga_rgb), 32'hF66);
    if (busy) busy_cnt++;
    for (int i = 0; i < 4; i++) begin
      cycle("hold", 1'b0, K_NONE, 3'b010);
      if (busy) busy_cnt++;
    end
    check("busy_len", 32'(busy_cnt), 32'd4);
    check("after_hold_rgb", 32'(vga_rgb), 32'hC33);
    check("after_hold_sel", 32'(sel_idx), 32'd1);

    // Reset in the middle of a hold aborts it
    cycle("enter2", 1'b1, K_ENTER, 3'b010);
    cycle("hold2", 1'b0, K_NONE, 3'b010);
    #1 rst = 1'b0;
    #1;
    check("arst_rgb",   32'(vga_rgb),   32'h000);
    check("arst_sel",   32'(sel_idx),   32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_pulse", 32'(btn_pulse), 32'd0);
    #1 rst = 1'b1;
    model_reset();

    // First edge after release accepts a key
    cycle("first_key", 1'b1, K_LEFT, 3'b001);
    cycle("post_rst_sel", 1'b0, K_NONE, 3'b001);
    for (int i = 0; i < 5; i++) cycle("post_rst_quiet", 1'b0, K_NONE, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_menu_compositor.md
VGA_MENU_COMPOSITOR -- requirements
Module: vga_menu_compositor

Interface
REQ-001 Parameter N_BTN, default 3, number of menu buttons (legal 2..8).
REQ-002 Parameter HOLD_CYC, default 8_200_000, clk cycles a pressed button stays highlighted (legal 1..2^24-1).
REQ-003 Parameter BG_COLOR, default 12'h0C6, background colour.
REQ-004 Parameter BTN_COLOR, default 12'h8C6, unselected button colour.
REQ-005 Parameter SEL_COLOR, default 12'hC33, selected button colour.
REQ-006 Parameter PRS_COLOR, default 12'hF66, pressed button colour.
REQ-007 clk  in  1  pixel clock; one clock only.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 hc_visible  in  11  visible horizontal counter; 0 = blanking.
REQ-010 vc_visible  in  11  visible vertical counter; 0 = blanking.
REQ-011 in_btn  in  N_BTN  pixel lies inside button k square.
REQ-012 in_char  in  1  pixel lies on any text glyph.
REQ-013 in_grid  in  1  pixel lies inside grid area.
REQ-014 grid_line  in  1  pixel lies on a grid line.
REQ-015 grid_en  in  1  grid lines shown (switch level).
REQ-016 key_valid  in  1  one-cycle strobe, key_code valid.
REQ-017 key_code  in  2  01 left, 10 right, 11 enter, 00 ignored.
REQ-018 vga_rgb  out  12  {R,G,B} 4 bits each, registered.
REQ-019 sel_idx  out  $clog2(N_BTN)  currently selected button.
REQ-020 btn_pulse  out  N_BTN  one-cycle one-hot press strobe.
REQ-021 busy  out  1  high while in PRESSED.

Function
REQ-022 FSM states IDLE, SELECT, PRESSED; IDLE entered from reset.
REQ-023 IDLE: left/right/enter -> SELECT with sel_idx=0, no pulse.
REQ-024 SELECT: right -> sel_idx+1, wrapping N_BTN-1 -> 0; left -> sel_idx-1, wrapping 0 -> N_BTN-1.
REQ-025 SELECT: enter -> PRESSED, btn_pulse[sel_idx]=1 for exactly the next cycle, timer loaded with HOLD_CYC-1.
REQ-026 PRESSED: timer decrements each cycle; at 0 -> SELECT next cycle; all keys ignored (no queueing).
REQ-027 key_code 00 with key_valid ignored in every state; key_valid low never changes state.
REQ-028 Colour priority per pixel: blanking (hc or vc = 0) -> 0; in_char -> 12'h000; in_btn[sel_idx] and PRESSED -> PRS_COLOR; in_btn[sel_idx] and SELECT -> SEL_COLOR; any other in_btn -> BTN_COLOR; in_grid and grid_line and grid_en -> 12'h666; in_grid -> 12'hCCC; else BG_COLOR.
REQ-029 In IDLE no button receives SEL_COLOR or PRS_COLOR.
REQ-030 vga_rgb latency exactly 1 clk from the pixel inputs; state used is the registered state of the same cycle.
REQ-031 Overlapping in_btn bits resolved by selection rule first, then lowest index as BTN_COLOR.

Reset
REQ-032 rst low asynchronously forces IDLE, sel_idx=0, timer=0, btn_pulse=0, busy=0, vga_rgb=0.
REQ-033 Reset during PRESSED aborts hold; no pulse is emitted after rst release until a new enter.
REQ-034 First key accepted on the first clk edge after rst release.

Configuration
REQ-035 Macro VGA_MENU_GRID_EN defined: grid layer per REQ-028.
REQ-036 Macro undefined: in_grid, grid_line, grid_en ignored; grid area shows BG_COLOR; ports retained.

Structure
REQ-037 Package menu_pkg holds key code constants, FSM state typedef, default colour constants.
REQ-038 Sub-module menu_sel_fsm holds FSM, sel_idx, timer, btn_pulse, busy; top holds colour mux and output register.

Verification
REQ-039 Reset, no keys, pixel (300,400) outside all regions -> vga_rgb=12'h0C6 one clk later; sel_idx=0.
REQ-040 N_BTN=3: right, right, right from SELECT at 0 -> sel_idx 1,2,0; left from 0 -> 2.
REQ-041 HOLD_CYC=4: enter at sel_idx=1 -> btn_pulse=3'b010 one cycle, busy high 4 cycles, button pixel PRS_COLOR then SEL_COLOR.
REQ-042 Right during PRESSED -> sel_idx unchanged, no pulse, returns to SELECT on schedule.
REQ-043 in_char and in_btn[sel_idx] both high -> 12'h000; hc_visible=0 -> 12'h000 regardless.
REQ-044 Macro on vs off with in_grid=grid_line=grid_en=1 -> 12'h666 vs 12'h0C6.
